data_mem_if: RTL

DATA_MEM_IF -- requirements
Module: data_mem_if

---
 rtl/data_mem_if.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_mem_if.sv
// Load/store bridge between a valid/ready request port and a 32-bit RAM with
// a one-cycle registered read and active-low byte-lane write enables.
module data_mem_if #(
  parameter int  depth = 256,
  localparam int AW    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [3:0]    ram_wen,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic        accept;
  logic        store_hit;
  logic [3:0]  lane_sel;

  // Misaligned, illegal size, or any address bit above the RAM's byte range.
  assign req_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                 | ((req_addr >> (AW + 2)) != 32'd0);

  // Gating with rst keeps the port closed and the RAM untouched during reset.
  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign store_hit = accept & req_we & ~req_err;

  assign ram_waddr = req_addr[AW+1:2];
  assign ram_raddr = req_addr[AW+1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_sel[gi] = (req_size == 2'd2)
                        | ((req_size == 2'd1) & (req_addr[1] == LANE[1]))
                        | ((req_size == 2'd0) & (req_addr[1:0] == LANE));
    assign ram_wen[gi]  = ~(store_hit & lane_sel[gi]);
  end

  always_comb begin
    ram_din = req_wdata;
    case (req_size)
      2'd0:    ram_din = {4{req_wdata[7:0]}};
      2'd1:    ram_din = {2{req_wdata[15:0]}};
      default: ram_din = req_wdata;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [1:0]  size,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = {{24{~uns & b[7]}}, b};
      2'd1:    r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = 32'd0;
          err_d   = req_err;
          if (req_err | req_we) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            off_d   = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
          end
        end
      end
      WAIT: begin
        rdata_d = extract(ram_dout, off_q, size_q, uns_q);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
